// File: rtl/vermicom_pkg.sv
// Vermicom_pkg: configuration constants for the Vermicom UART block.
//   RX_FIFO_DEPTH : default number of byte entries in the receive FIFO.
package Vermicom_pkg;

    localparam int unsigned RX_FIFO_DEPTH = 16;

endpackage : Vermicom_pkg

// File: rtl/vermitypes_pkg.sv
// Vermitypes_pkg: basic data types shared across the Vermicom design.
//   byte_t : one 8-bit data byte as moved between UART, FIFOs and bus.
package Vermitypes_pkg;

    typedef logic [7:0] byte_t;

endpackage : Vermitypes_pkg

// File: rtl/vermicom_rx_fifo.sv
// vermicom_rx_fifo: receive FIFO between the UART RX deserializer and the
// data-register read path. Circular buffer with (log2(DEPTH)+1)-bit pointers;
// the extra MSB separates full from empty after wrap-around.
//
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   push, push_data     - receiver strobe and byte
//   pop, pop_data       - bus read strobe; show-ahead head byte
//   not_empty, full     - occupancy flags (from registered pointers only)
//   count               - number of stored bytes
//   flush               - synchronous clear (wins over push/pop/overrun set)
//   overrun             - sticky "byte dropped" flag
//   overrun_clear       - write-1-to-clear for overrun (a same-cycle set wins)
//   threshold, watermark- only with VERMICOM_RX_FIFO_WATERMARK_EN defined;
//                         watermark = registered (count >= threshold && threshold != 0)
module vermicom_rx_fifo
    import Vermicom_pkg::*;
    import Vermitypes_pkg::*;
#(
    parameter int unsigned DEPTH = RX_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  byte_t                  push_data,
    input  logic                   pop,
    output byte_t                  pop_data,
    output logic                   not_empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   flush,
`ifdef VERMICOM_RX_FIFO_WATERMARK_EN
    input  logic [$clog2(DEPTH):0] threshold,
    output logic                   watermark,
`endif
    output logic                   overrun,
    input  logic                   overrun_clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    byte_t       mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overrun_q, overrun_d;
    logic        do_push, do_pop, drop;

    // Status comes from registered pointers only.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign not_empty = (wr_ptr_q != rd_ptr_q);
    assign full      = (count == DEPTH_CNT);
    assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign overrun   = overrun_q;

    always_comb begin
        do_pop   = pop && not_empty && !flush;
        // A pop in the same cycle frees the slot, so a push is accepted when full.
        do_push  = push && !flush && (!full || do_pop);
        drop     = push && full && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (flush)              overrun_d = 1'b0;
        else if (drop)          overrun_d = 1'b1;
        else if (overrun_clear) overrun_d = 1'b0;
        else                    overrun_d = overrun_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is not reset; pop_data is meaningless while not_empty is low.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

`ifdef VERMICOM_RX_FIFO_WATERMARK_EN
    logic [AW:0] count_d;
    logic        watermark_q;

    // Compare against the next count so the registered flag lines up with count.
    assign count_d   = wr_ptr_d - rd_ptr_d;
    assign watermark = watermark_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) watermark_q <= 1'b0;
        else       watermark_q <= (count_d >= threshold) && (threshold != '0);
    end
`endif

endmodule : vermicom_rx_fifo

// File: doc/vermicom_rx_fifo.md
VERMICOM_RX_FIFO -- requirements
Module: vermicom_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, at least 2.
REQ-002 Port clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port push  input  1  UART receiver strobe, one cycle per received byte.
REQ-005 Port push_data  input  8  received byte, valid when push=1.
REQ-006 Port pop  input  1  bus read of the data register consumes the head byte.
REQ-007 Port pop_data  output  8  head byte, show-ahead (valid whenever not_empty=1).
REQ-008 Port not_empty  output  1  at least one byte stored.
REQ-009 Port full  output  1  DEPTH bytes stored.
REQ-010 Port count  output  $clog2(DEPTH)+1  number of stored bytes.
REQ-011 Port flush  input  1  synchronous clear request from the control register.
REQ-012 Port overrun  output  1  sticky flag: a byte was dropped.
REQ-013 Port overrun_clear  input  1  write-1-to-clear strobe from the status register.

Function
REQ-014 Storage SHALL be a circular buffer with read and write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap-around.
REQ-015 push with full=0 SHALL store push_data; count SHALL increment on the next edge.
REQ-016 pop with not_empty=1 SHALL advance the read pointer; pop_data SHALL show the next byte in the following cycle, with zero read latency.
REQ-017 pop with not_empty=0 SHALL be ignored.
REQ-018 push and pop in the same cycle with not_empty=1 SHALL both take effect, and count SHALL be unchanged, including when full=1.
REQ-019 push and pop in the same cycle with count=0 SHALL store the byte, ignore the pop, and set count=1.
REQ-020 push with full=1 and no pop SHALL drop the byte, leave the contents unchanged, and set overrun on the next edge.
REQ-021 overrun SHALL stay set until an overrun_clear; if a set and a clear happen in the same cycle, the set SHALL win.
REQ-022 flush SHALL empty the buffer and clear overrun on the next edge; flush SHALL win over a simultaneous push, pop or overrun set.
REQ-023 Pointers SHALL wrap modulo 2*DEPTH with no gap or repeated byte across the wrap.
REQ-024 full, not_empty and count SHALL be derived from registered pointers only; no output SHALL depend combinationally on push or pop.

Reset
REQ-025 While reset=1, pointers SHALL be 0, count=0, not_empty=0, full=0 and overrun=0, independent of clk.
REQ-026 Storage contents need not be reset, and pop_data SHALL be ignored while not_empty=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored bytes immediately.

Configuration
REQ-028 With macro VERMICOM_RX_FIFO_WATERMARK_EN defined, the block SHALL add port threshold (input, $clog2(DEPTH)+1 bits) and port watermark (output, 1 bit); watermark SHALL be registered and equal to (count >= threshold && threshold != 0).
REQ-029 Without VERMICOM_RX_FIFO_WATERMARK_EN, neither the threshold nor the watermark port SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-030 The default depth constant RX_FIFO_DEPTH SHALL live in Vermicom_pkg; the byte type SHALL come from Vermitypes_pkg.
REQ-031 The block SHALL contain no sub-module, with storage, pointers and flags inline; Vermicom SHALL instantiate it between its RX deserializer and its data register read path.

Verification
REQ-032 Reset then push 0x53 -> one cycle later not_empty=1, count=1, pop_data=0x53; pop -> not_empty=0 next cycle.
REQ-033 Push DEPTH bytes 0x00..0x0F -> full=1, count=16; push 0xAA -> overrun=1 and pop sequence 0x00..0x0F with 0xAA absent.
REQ-034 Keep count at 8 for 40 cycles with simultaneous push/pop of incrementing data -> bytes leave in order across a pointer wrap and count stays 8.
REQ-035 Full with simultaneous push 0xCA and pop -> no overrun, count=16, 0xCA is the last byte read.
REQ-036 overrun set, then overrun_clear pulsed together with a dropped push -> overrun stays 1; overrun_clear alone -> overrun=0; flush -> count=0 and overrun=0.
REQ-037 With VERMICOM_RX_FIFO_WATERMARK_EN and threshold=4, push 4 bytes -> watermark=1 after the 4th push; one pop -> watermark=0; threshold=0 -> watermark stays 0.
